// File: rtl/vga_coord_gen_if.sv
// vga_coord_gen_if: coordinate/object/video signal bundle between the VGA timing generator and its object renderer.
interface vga_coord_gen_if;
    logic [10:0] oCoord_X;
    logic [10:0] oCoord_Y;
    logic        drawing_request;
    logic [7:0]  mVGA_RGB;
    logic [7:0]  VGA_RGB;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;
    logic        frame_start;
    modport master (
        output oCoord_X, oCoord_Y, VGA_RGB, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start,
        input  drawing_request, mVGA_RGB
    );
    modport slave (
        input  oCoord_X, oCoord_Y, VGA_RGB, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start,
        output drawing_request, mVGA_RGB
    );
endinterface

// File: rtl/vga_coord_gen.sv
// vga_coord_gen: VGA raster counters plus sync/blank decode, delayed to line up with an object renderer of fixed latency.
module vga_coord_gen #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned OBJ_LATENCY = 1,
    parameter logic [7:0]  BG_COLOR    = 8'h00
) (
    input logic CLK,
    input logic RESET,
    vga_coord_gen_if.master vga
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned PW      = 3 * OBJ_LATENCY;
    logic [10:0]   h_q, h_d, v_q, v_d;
    logic          h_wrap;
    logic [2:0]    dec;
    logic [PW-1:0] pipe_q;
    logic [PW+2:0] shift;
    logic [2:0]    tap;
    logic [7:0]    rgb_q, rgb_d;
    logic          hs_n_q, vs_n_q, blank_n_q;
    // dec/tap are {visible, hsync_active, vsync_active}; pipe holds OBJ_LATENCY copies
    always_comb begin
        h_wrap = h_q == 11'(H_TOTAL - 1);
        h_d    = h_wrap ? '0 : h_q + 11'd1;
        v_d    = !h_wrap ? v_q : (v_q == 11'(V_TOTAL - 1)) ? '0 : v_q + 11'd1;
        dec    = {h_q < 11'(H_ACTIVE) && v_q < 11'(V_ACTIVE),
                  h_q >= 11'(H_ACTIVE + H_FP) && h_q < 11'(H_ACTIVE + H_FP + H_SYNC),
                  v_q >= 11'(V_ACTIVE + V_FP) && v_q < 11'(V_ACTIVE + V_FP + V_SYNC)};
        shift  = {pipe_q, dec};
        tap    = pipe_q[PW-1 -: 3];
        rgb_d  = !tap[2] ? 8'h00 : vga.drawing_request ? vga.mVGA_RGB : BG_COLOR;
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            h_q       <= '0;
            v_q       <= '0;
            pipe_q    <= '0;
            rgb_q     <= 8'h00;
            hs_n_q    <= 1'b1;
            vs_n_q    <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            pipe_q    <= shift[PW-1:0];
            rgb_q     <= rgb_d;
            hs_n_q    <= ~tap[1];
            vs_n_q    <= ~tap[0];
            blank_n_q <= tap[2];
        end
    end
    assign vga.oCoord_X    = h_q;
    assign vga.oCoord_Y    = v_q;
    assign vga.VGA_RGB     = rgb_q;
    assign vga.VGA_HS      = hs_n_q;
    assign vga.VGA_VS      = vs_n_q;
    assign vga.VGA_BLANK_N = blank_n_q;
    assign vga.frame_start = h_q == '0 && v_q == '0 && !RESET;
endmodule
